// File: rtl/logic_reduce_unit.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready handshake and multi-beat accumulation.
// Optional beat counter output out_beats is enabled by defining LOGIC_REDUCE_COUNT_EN.
module logic_reduce_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
`ifdef LOGIC_REDUCE_COUNT_EN
  ,
  output logic [7:0]       out_beats
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] result;

`ifdef LOGIC_REDUCE_COUNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] beats_q, beats_d;
  logic [7:0] cnt_inc;
`endif

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       f,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (f)
      3'd0:    r = ~(a & b);
      3'd1:    r = ~(a | b);
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_zero  = (out_q == '0);

  // In ACC the running value replaces operand A and the latched op replaces op.
  assign op_sel    = (state_q == IDLE) ? op : op_q;
  assign operand_a = (state_q == IDLE) ? in0 : acc_q;
  assign result    = apply_op(op_sel, operand_a, in1);

`ifdef LOGIC_REDUCE_COUNT_EN
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign out_beats = beats_q;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready;
`ifdef LOGIC_REDUCE_COUNT_EN
    cnt_d       = cnt_q;
    beats_d     = beats_q;
`endif
    if (accept) begin
      case (state_q)
        IDLE: begin
          op_d = op;
`ifdef LOGIC_REDUCE_COUNT_EN
          cnt_d = 8'd1;
`endif
          if (in_last || !acc_mode) begin
            out_d       = result;
            out_valid_d = 1'b1;
`ifdef LOGIC_REDUCE_COUNT_EN
            beats_d     = 8'd1;
`endif
          end else begin
            acc_d   = result;
            state_d = ACC;
          end
        end
        ACC: begin
`ifdef LOGIC_REDUCE_COUNT_EN
          cnt_d = cnt_inc;
`endif
          if (in_last) begin
            out_d       = result;
            out_valid_d = 1'b1;
            state_d     = IDLE;
`ifdef LOGIC_REDUCE_COUNT_EN
            beats_d     = cnt_inc;
`endif
          end else begin
            acc_d = result;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef LOGIC_REDUCE_COUNT_EN
      cnt_q       <= '0;
      beats_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef LOGIC_REDUCE_COUNT_EN
      cnt_q       <= cnt_d;
      beats_q     <= beats_d;
`endif
    end
  end

endmodule
